// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM state
// type, request payload and the default memory depth.
package mem_access_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 32;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ADDR_W            = 32;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Request fields captured at acceptance.
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              is_signed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Size/alignment part of the error check (range is checked by the caller).
  function automatic logic access_illegal(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    case (size)
      SZ_HALF:    return addr_lo[0];
      SZ_WORD:    return addr_lo != 2'b00;
      SZ_ILLEGAL: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bus of the memory access unit.
//   master : CPU (drives request fields and resp_ready)
//   slave  : mem_access_unit (drives req_ready and response fields)
interface mem_access_unit_if;
  import mem_access_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
           resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: combinational lane handling for sub-word accesses.
//   mem_word     : word read from memory
//   addr_lo      : byte offset inside the word
//   size         : access size encoding
//   is_signed    : sign-extend sub-word loads
//   store_data   : store payload (byte in [7:0], half in [15:0])
//   load_data_c  : extracted/extended load result
//   merge_data_c : word to write back (store lane merged into mem_word)
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] mem_word,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Word accesses pass straight through; sub-word accesses select a lane.
  always_comb begin
    byte_shift   = {addr_lo, 3'b000};
    half_shift   = {addr_lo[1], 4'b0000};
    byte_lane    = mem_word[byte_shift +: 8];
    half_lane    = mem_word[half_shift +: 16];
    load_data_c  = mem_word;
    merge_data_c = store_data;
    case (size)
      SZ_BYTE: begin
        load_data_c  = {{24{is_signed & byte_lane[7]}}, byte_lane};
        merge_data_c = mem_word;
        merge_data_c[byte_shift +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        load_data_c  = {{16{is_signed & half_lane[15]}}, half_lane};
        merge_data_c = mem_word;
        merge_data_c[half_shift +: 16] = store_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences CPU loads/stores onto a word-wide data memory,
// doing lane extraction for sub-word loads and read-modify-write for
// sub-word stores.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   cpu            : request/response bus (slave side)
//   mem_read       : memory read strobe (data returns on mem_result next cycle)
//   mem_write      : memory write strobe
//   mem_address    : word index, 0 when no strobe
//   mem_write_data : word to write, 0 when not writing
//   mem_result     : memory read data
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  mem_access_unit_if.slave  cpu,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_result
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * MEM_WORDS);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  req_t              req_in;
  logic              in_err;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] merge_data_c;

  mem_lane_align u_lane (
    .mem_word     (mem_result),
    .addr_lo      (req_q.addr[1:0]),
    .size         (req_q.size),
    .is_signed    (req_q.is_signed),
    .store_data   (req_q.wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // State and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      req_q            <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // Next state plus next values of every output; outputs are computed for
  // the state being entered so they line up with it after the edge.
  always_comb begin
    req_in.write     = cpu.req_write;
    req_in.size      = cpu.req_size;
    req_in.is_signed = cpu.req_signed;
    req_in.addr      = cpu.req_addr;
    req_in.wdata     = cpu.req_wdata;
    in_err = access_illegal(cpu.req_size, cpu.req_addr[1:0]) ||
             (cpu.req_addr >= ADDR_LIMIT);

    state_d          = state_q;
    req_d            = req_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_rdata_d     = '0;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_address_d    = '0;
    mem_write_data_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu.req_valid && req_ready_q) begin
          req_d = req_in;
          if (in_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (cpu.req_write && (cpu.req_size == SZ_WORD)) begin
            state_d          = ST_WRITE;
            mem_write_d      = 1'b1;
            mem_address_d    = {2'b00, cpu.req_addr[ADDR_W-1:2]};
            mem_write_data_d = cpu.req_wdata;
          end else begin
            // Loads and sub-word stores both start by reading the word.
            state_d       = ST_READ;
            mem_read_d    = 1'b1;
            mem_address_d = {2'b00, cpu.req_addr[ADDR_W-1:2]};
          end
        end
      end
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (req_q.write) begin
          state_d          = ST_WRITE;
          mem_write_d      = 1'b1;
          mem_address_d    = {2'b00, req_q.addr[ADDR_W-1:2]};
          mem_write_data_d = merge_data_c;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data_c;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (cpu.resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = resp_err_q;
          resp_rdata_d = resp_rdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  assign cpu.req_ready   = req_ready_q;
  assign cpu.resp_valid  = resp_valid_q;
  assign cpu.resp_err    = resp_err_q;
  assign cpu.resp_rdata  = resp_rdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_write_data  = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests, a word-level reference model
// checked against the DUT every cycle, plus literal expectations.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int unsigned MW = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_result;

  mem_access_unit_if cpu_if();

  mem_access_unit #(.MEM_WORDS(MW)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu            (cpu_if),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_result     (mem_result)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Data memory attached to the DUT: one-cycle read latency.
  logic [31:0] dmem [MW];
  bit          dmem_ready = 1'b0;
  always @(posedge clock) begin
    if (!dmem_ready) begin
      for (int i = 0; i < int'(MW); i++) dmem[i] <= 32'(i);
      mem_result <= '0;
      dmem_ready <= 1'b1;
    end else begin
      if (mem_read)  mem_result <= dmem[mem_address[4:0]];
      if (mem_write) dmem[mem_address[4:0]] <= mem_write_data;
    end
  end

  // Strobe tracker.
  int          rd_pulses = 0, wr_pulses = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  always @(negedge clock) begin
    if (mem_read)  begin rd_pulses++; last_rd_addr = mem_address; end
    if (mem_write) begin wr_pulses++; last_wr_addr = mem_address; last_wr_data = mem_write_data; end
  end

  // Reference model: byte-addressed semantics on a plain word array.
  logic [31:0] ref_mem [MW];
  bit          ref_ready = 1'b0;

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return a >= 4 * MW;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = ref_mem[int'(a / 4)];
    sh = 8 * int'(a % 4);
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w, mask;
    int sh;
    if (sz == 2'd2) return d;
    w    = ref_mem[int'(a / 4)];
    sh   = 8 * int'(a % 4);
    mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // Compare process: expected per-cycle outputs derived from access class.
  bit          mon_en = 1'b0;
  bit          m_busy = 1'b0;
  int          m_off, m_rd_off, m_wr_off, m_resp_off;
  logic        m_err, m_in_resp, m_strobe;
  logic [31:0] m_addr, m_rdata, m_wword;

  always @(negedge clock) begin
    if (!mon_en) begin
      m_busy = 1'b0;
      if (!ref_ready) begin
        for (int i = 0; i < int'(MW); i++) ref_mem[i] = 32'(i);
        ref_ready = 1'b1;
      end
    end else if (!m_busy) begin
      chkb("idle_req_ready", cpu_if.req_ready, 1'b1);
      chkb("idle_resp_valid", cpu_if.resp_valid, 1'b0);
      chkb("idle_mem_read", mem_read, 1'b0);
      chkb("idle_mem_write", mem_write, 1'b0);
      chk("idle_mem_address", mem_address, 32'h0);
      chk("idle_mem_wdata", mem_write_data, 32'h0);
      if (cpu_if.req_valid) begin
        m_addr   = cpu_if.req_addr;
        m_err    = model_err(cpu_if.req_size, m_addr);
        m_rdata  = '0;
        m_wword  = '0;
        m_rd_off = 0;
        m_wr_off = 0;
        if (m_err) begin
          m_resp_off = 1;
        end else if (cpu_if.req_write && cpu_if.req_size == 2'd2) begin
          m_wr_off   = 1;
          m_resp_off = 2;
          m_wword    = cpu_if.req_wdata;
          ref_mem[int'(m_addr / 4)] = m_wword;
        end else if (!cpu_if.req_write) begin
          m_rd_off   = 1;
          m_resp_off = 3;
          m_rdata    = model_load(cpu_if.req_size, cpu_if.req_signed, m_addr);
        end else begin
          m_rd_off   = 1;
          m_wr_off   = 3;
          m_resp_off = 4;
          m_wword    = model_merge(cpu_if.req_size, m_addr, cpu_if.req_wdata);
          ref_mem[int'(m_addr / 4)] = m_wword;
        end
        m_off  = 0;
        m_busy = 1'b1;
      end
    end else begin
      m_off++;
      m_in_resp = (m_off >= m_resp_off);
      m_strobe  = (m_off == m_rd_off) || (m_off == m_wr_off);
      chkb("busy_req_ready", cpu_if.req_ready, 1'b0);
      chkb("mem_read", mem_read, m_off == m_rd_off);
      chkb("mem_write", mem_write, m_off == m_wr_off);
      chk("mem_address", mem_address, m_strobe ? (m_addr / 4) : 32'h0);
      chk("mem_wdata", mem_write_data, (m_off == m_wr_off) ? m_wword : 32'h0);
      chkb("resp_valid", cpu_if.resp_valid, m_in_resp);
      chk("resp_rdata", cpu_if.resp_rdata, m_in_resp ? m_rdata : 32'h0);
      chkb("resp_err", cpu_if.resp_err, m_in_resp ? m_err : 1'b0);
      if (m_in_resp && cpu_if.resp_ready) m_busy = 1'b0;
    end
  end

  // Issue one request; called and returns just after a rising edge.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input int hold,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nrd, output int nwr);
    int n, rd_base, wr_base;
    rd_base = rd_pulses;
    wr_base = wr_pulses;
    cpu_if.resp_ready = (hold == 0);
    cpu_if.req_valid  = 1'b1;
    cpu_if.req_write  = w;
    cpu_if.req_size   = sz;
    cpu_if.req_signed = sg;
    cpu_if.req_addr   = a;
    cpu_if.req_wdata  = d;
    n = 0;
    while (!cpu_if.req_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (n >= 20) chkb("accept_timeout", 1'b0, 1'b1);
    @(posedge clock); #1;
    cpu_if.req_valid = 1'b0;
    n = 0;
    while (!cpu_if.resp_valid && n < 10) begin @(posedge clock); #1; n++; end
    lat   = n + 1;
    rdata = cpu_if.resp_rdata;
    err   = cpu_if.resp_err;
    for (int i = 0; i < hold; i++) begin @(posedge clock); #1; end
    cpu_if.resp_ready = 1'b1;
    @(posedge clock); #1;
    nrd = rd_pulses - rd_base;
    nwr = wr_pulses - wr_base;
  endtask

  int          lat, nrd, nwr, wr_base;
  logic [31:0] rd;
  logic        er;

  initial begin
    reset             = 1'b1;
    cpu_if.req_valid  = 1'b0;
    cpu_if.req_write  = 1'b0;
    cpu_if.req_size   = SZ_WORD;
    cpu_if.req_signed = 1'b0;
    cpu_if.req_addr   = '0;
    cpu_if.req_wdata  = '0;
    cpu_if.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chkb("rst_req_ready", cpu_if.req_ready, 1'b1);
    chkb("rst_resp_valid", cpu_if.resp_valid, 1'b0);
    chkb("rst_resp_err", cpu_if.resp_err, 1'b0);
    chk("rst_resp_rdata", cpu_if.resp_rdata, 32'h0);
    chkb("rst_mem_read", mem_read, 1'b0);
    chkb("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Load word at 0x0C
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lw0c_rdata", rd, 32'h0000_0003);
    chk("lw0c_latency", 32'(lat), 32'd3);
    chkb("lw0c_err", er, 1'b0);
    chk("lw0c_reads", 32'(nrd), 32'd1);
    chk("lw0c_rd_addr", last_rd_addr, 32'd3);

    // Store word then load it back
    do_req(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF, 0, lat, rd, er, nrd, nwr);
    chk("sw08_writes", 32'(nwr), 32'd1);
    chk("sw08_reads", 32'(nrd), 32'd0);
    chk("sw08_wr_addr", last_wr_addr, 32'd2);
    chk("sw08_latency", 32'(lat), 32'd2);
    chk("sw08_rdata", rd, 32'h0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lw08_rdata", rd, 32'hDEAD_BEEF);

    // Byte store via read-modify-write, then signed/unsigned byte loads
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h05, 32'h1234_5680, 0, lat, rd, er, nrd, nwr);
    chk("sb05_wdata", last_wr_data, 32'h0000_8001);
    chk("sb05_wr_addr", last_wr_addr, 32'd1);
    chk("sb05_latency", 32'(lat), 32'd4);
    chk("sb05_writes", 32'(nwr), 32'd1);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h05, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lb05_signed", rd, 32'hFFFF_FF80);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h05, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lb05_unsigned", rd, 32'h0000_0080);

    // Error cases: misaligned half, out of range, illegal size, misaligned store
    do_req(1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 0, lat, rd, er, nrd, nwr);
    chkb("lh03_err", er, 1'b1);
    chk("lh03_latency", 32'(lat), 32'd1);
    chk("lh03_strobes", 32'(nrd + nwr), 32'd0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 0, lat, rd, er, nrd, nwr);
    chkb("lw80_err", er, 1'b1);
    chk("lw80_latency", 32'(lat), 32'd1);
    chk("lw80_strobes", 32'(nrd + nwr), 32'd0);
    chk("lw80_rdata", rd, 32'h0);
    do_req(1'b0, SZ_ILLEGAL, 1'b0, 32'h00, 32'h0, 0, lat, rd, er, nrd, nwr);
    chkb("size3_err", er, 1'b1);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h06, 32'h5555_5555, 0, lat, rd, er, nrd, nwr);
    chkb("sw06_err", er, 1'b1);
    chk("sw06_writes", 32'(nwr), 32'd0);

    // Half store on the upper lane, then half/word loads
    do_req(1'b1, SZ_HALF, 1'b0, 32'h1A, 32'hFFFF_8001, 0, lat, rd, er, nrd, nwr);
    chk("sh1a_wdata", last_wr_data, 32'h8001_0006);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h1A, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lh1a_signed", rd, 32'hFFFF_8001);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h18, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lh18_unsigned", rd, 32'h0000_0006);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lw18", rd, 32'h8001_0006);

    // Top of the address range
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h7C, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lb7c", rd, 32'h0000_001F);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h7F, 32'h0, 0, lat, rd, er, nrd, nwr);
    chkb("lb7f_err", er, 1'b0);
    chk("lb7f", rd, 32'h0);

    // Response held for three cycles before being accepted
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 3, lat, rd, er, nrd, nwr);
    chk("hold_rdata", rd, 32'h0000_0003);
    chk("hold_after_rdata", cpu_if.resp_rdata, 32'h0);

    // Reset during the LATCH cycle of a half store at 0x10
    mon_en            = 1'b0;
    wr_base           = wr_pulses;
    cpu_if.resp_ready = 1'b1;
    cpu_if.req_valid  = 1'b1;
    cpu_if.req_write  = 1'b1;
    cpu_if.req_size   = SZ_HALF;
    cpu_if.req_signed = 1'b0;
    cpu_if.req_addr   = 32'h10;
    cpu_if.req_wdata  = 32'h0000_BEEF;
    @(posedge clock); #1;
    cpu_if.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chkb("abort_mem_write", mem_write, 1'b0);
      chkb("abort_resp_valid", cpu_if.resp_valid, 1'b0);
      chkb("abort_req_ready", cpu_if.req_ready, 1'b1);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_writes", 32'(wr_pulses - wr_base), 32'd0);
    mon_en = 1'b1;
    @(posedge clock); #1;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, lat, rd, er, nrd, nwr);
    chk("lw10_after_abort", rd, 32'h0000_0004);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
